// File: rtl/ebp_frame_stack_if.sv
// Command/status bundle between the decoder and the EBP frame stack.
// The master drives commands; the slave returns the frame pointer and stack status.
interface ebp_frame_stack_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [3:0]       read_or_write;
   logic [WIDTH-1:0] write_data;
   logic [WIDTH-1:0] ebp;
   logic [CW-1:0]    depth_count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output read_or_write, write_data,
      input  ebp, depth_count, full, empty, overflow, underflow
   );

   modport slave (
      input  read_or_write, write_data,
      output ebp, depth_count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/ebp_frame_stack.sv
// Frame-pointer register with a LIFO of saved frame pointers.
// ENTER saves the old ebp and loads a new one; LEAVE restores the most recently saved ebp.
module ebp_frame_stack #(
   parameter int unsigned          WIDTH       = 32,
   parameter int unsigned          DEPTH       = 8,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input logic                clock_5,
   input logic                reset,
   ebp_frame_stack_if.slave   bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [3:0] CMD_WRITE  = 4'h2;
   localparam logic [3:0] CMD_ENTER  = 4'h3;
   localparam logic [3:0] CMD_LEAVE  = 4'h4;
   localparam logic [3:0] CMD_FLUSH  = 4'h5;
   localparam logic [3:0] CMD_CLRERR = 4'hF;

   logic [WIDTH-1:0] ebp_q, ebp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push_en;
   logic             full_c, empty_c;
   logic [WIDTH-1:0] stack_q [DEPTH];

   assign full_c  = (cnt_q == CW'(DEPTH));
   assign empty_c = (cnt_q == '0);

   // Next-state for ebp, saved-frame count and sticky error flags.
   always_comb begin
      ebp_d   = ebp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      case (bus.read_or_write)
         CMD_WRITE: ebp_d = bus.write_data;
         CMD_ENTER: begin
            if (full_c) begin
               ovf_d = 1'b1;
            end else begin
               push_en = 1'b1;
               ebp_d   = bus.write_data;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         CMD_LEAVE: begin
            if (empty_c) begin
               unf_d = 1'b1;
            end else begin
               ebp_d = stack_q[AW'(cnt_q - CW'(1))];
               cnt_d = cnt_q - CW'(1);
            end
         end
         CMD_FLUSH: cnt_d = '0;
         CMD_CLRERR: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_5) begin
      if (reset) begin
         ebp_q <= RESET_VALUE;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ebp_q <= ebp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clock_5) begin
      if (push_en) begin
         stack_q[AW'(cnt_q)] <= ebp_q;
      end
   end

   assign bus.ebp         = ebp_q;
   assign bus.depth_count = cnt_q;
   assign bus.full        = full_c;
   assign bus.empty       = empty_c;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_ebp_frame_stack.sv
// Scoreboard bench for ebp_frame_stack: a queue-based frame model predicts each
// post-edge state, and a monitor compares it against the DUT one step after every edge.
module tb_ebp_frame_stack;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 8;

   typedef struct {
      logic [31:0] ebp;
      int unsigned depth;
      bit          ovf;
      bit          unf;
      string       tag;
   } exp_t;

   logic clock_5 = 1'b0;
   logic reset   = 1'b1;

   ebp_frame_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   ebp_frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE('0)) dut (
      .clock_5 (clock_5),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clock_5 = ~clock_5;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   // Reference model state: saved frames as a plain queue, top at the back.
   logic [31:0] m_ebp = '0;
   logic [31:0] m_stk[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;

   task automatic cmp(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s [%s] got=%0h expected=%0h", name, tag, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] cmd, input logic [31:0] data, input bit rst, input string tag);
      exp_t e;
      @(negedge clock_5);
      reset = rst;
      bus.read_or_write = cmd;
      bus.write_data    = data;
      if (rst) begin
         m_ebp = '0;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         case (cmd)
            4'h2: m_ebp = data;
            4'h3: begin
               if (m_stk.size() == DEPTH) m_ovf = 1'b1;
               else begin
                  m_stk.push_back(m_ebp);
                  m_ebp = data;
               end
            end
            4'h4: begin
               if (m_stk.size() == 0) m_unf = 1'b1;
               else m_ebp = m_stk.pop_back();
            end
            4'h5: m_stk.delete();
            4'hF: begin
               m_ovf = 1'b0;
               m_unf = 1'b0;
            end
            default: ;
         endcase
      end
      e.ebp   = m_ebp;
      e.depth = m_stk.size();
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: one prediction per edge, compared after the outputs settle.
   always @(posedge clock_5) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("ebp",         e.tag, bus.ebp, e.ebp);
         cmp("depth_count", e.tag, 32'(bus.depth_count), e.depth);
         cmp("full",        e.tag, 32'(bus.full),  32'(e.depth == DEPTH));
         cmp("empty",       e.tag, 32'(bus.empty), 32'(e.depth == 0));
         cmp("overflow",    e.tag, 32'(bus.overflow),  32'(e.ovf));
         cmp("underflow",   e.tag, 32'(bus.underflow), 32'(e.unf));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] cmd;
      bus.read_or_write = 4'h0;
      bus.write_data    = '0;

      issue(4'h0, 32'h0, 1'b1, "reset");

      issue(4'h2, 32'h1000, 1'b0, "write");
      issue(4'h3, 32'h2000, 1'b0, "enter");
      issue(4'h4, 32'h0,    1'b0, "leave");

      issue(4'h0, 32'h0, 1'b1, "reset2");
      for (int i = 1; i <= 8; i++) issue(4'h3, 32'(i * 16), 1'b0, "fill");
      issue(4'h3, 32'h90, 1'b0, "enter_full");
      for (int i = 0; i < 8; i++) issue(4'h4, 32'h0, 1'b0, "drain");

      issue(4'h4, 32'h0, 1'b0, "leave_empty");
      issue(4'hF, 32'h0, 1'b0, "clrerr");

      issue(4'h3, 32'h300, 1'b0, "enter_pre_reset");
      issue(4'h3, 32'h400, 1'b1, "reset_with_enter");
      issue(4'h4, 32'h0,   1'b0, "leave_after_reset");
      issue(4'hF, 32'h0,   1'b0, "clrerr2");

      issue(4'h3, 32'hA0, 1'b0, "enter_a0");
      issue(4'h5, 32'h0,  1'b0, "flush");
      issue(4'h7, 32'hDEAD, 1'b0, "unused_7");

      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 11))
            0:       cmd = 4'h0;
            1:       cmd = 4'h2;
            2, 3, 4: cmd = 4'h3;
            5, 6, 7: cmd = 4'h4;
            8:       cmd = 4'h5;
            9:       cmd = 4'hF;
            10:      cmd = 4'(($urandom_range(0, 1) == 0) ? 4'h1 : 4'h9);
            default: cmd = 4'h3;
         endcase
         issue(cmd, $urandom, ($urandom_range(0, 99) == 0), "random");
      end

      issue(4'h0, 32'h0, 1'b0, "tail");
      @(negedge clock_5);
      @(negedge clock_5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
